// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed scan controller for the SPI byte display: selects the rx/tx byte per frame,
// drives digit select, blanking and frame ticks. Optional receive-blink feature: `define DISP_BLINK_EN.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  input  logic       mode,
  output logic [7:0] disp_byte,
  output logic       digit_sel,
  output logic       blank,
  output logic       frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20) || BLINK_FRAMES > (1 << 16)) begin : g_param_check
    $error("display_scan_ctrl: REFRESH_DIV or BLINK_FRAMES out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHOW_RX = 2'b01,
    SHOW_TX = 2'b11
  } state_t;

  logic [CW-1:0] prescale;
  logic          digit_tick;
  logic [7:0]    rx_hold;
  logic [7:0]    tx_hold;
  logic          rx_seen;
  logic          tx_seen;
  logic          blink_on;
  logic          blink_blank;
  state_t        state;
  state_t        next_state;

  assign digit_tick = (prescale == TERM);
  assign frame_tick = digit_tick & digit_sel;

  // NOTE: sequential state is always updated with <= so every register samples pre-edge values;
  // this is what makes a capture coinciding with frame_tick show the old hold byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale  <= '0;
      digit_sel <= 1'b0;
    end else if (digit_tick) begin
      prescale  <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      prescale  <= prescale + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hold <= '0;
      rx_seen <= 1'b0;
      tx_hold <= '0;
      tx_seen <= 1'b0;
    end else begin
      if (rx_valid) begin
        rx_hold <= rx_data;
        rx_seen <= 1'b1;
      end
      if (tx_load) begin
        tx_hold <= tx_data;
        tx_seen <= 1'b1;
      end
    end
  end

  // NOTE: next_state gets a default before any condition so the block can never infer a latch.
  always_comb begin
    next_state = IDLE;
    if (!mode && rx_seen) begin
      next_state = SHOW_RX;
    end else if (mode && tx_seen) begin
      next_state = SHOW_TX;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else if (rx_valid) begin
      blink_cnt <= BW'(BLINK_FRAMES);
    end else if (frame_tick && blink_cnt != '0) begin
      blink_cnt <= blink_cnt - BW'(1);
    end
  end

  // An odd count is nonzero by definition, so bit 0 alone marks the dark frames.
  assign blink_on = blink_cnt[0];
`else
  assign blink_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      disp_byte   <= 8'h00;
      blink_blank <= 1'b0;
    end else if (frame_tick) begin
      state       <= next_state;
      blink_blank <= (next_state == SHOW_RX) && blink_on;
      unique case (next_state)
        SHOW_RX: disp_byte <= rx_hold;
        SHOW_TX: disp_byte <= tx_hold;
        default: disp_byte <= 8'h00;
      endcase
    end
  end

  // Decoded straight from registers, so blank changes only at frame boundaries.
  assign blank = (state == IDLE) || ((state == SHOW_RX) && blink_blank);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (REFRESH_DIV=4): frame-level timing model compared every
// cycle, plus directed scenarios with literal expectations. Honours `define DISP_BLINK_EN.
module tb_display_scan_ctrl;

  localparam int DIV    = 4;
  localparam int BLINK  = 4;
  localparam int FRAME  = 2 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       mode = 1'b0;
  logic [7:0] disp_byte;
  logic       digit_sel;
  logic       blank;
  logic       frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  display_scan_ctrl #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BLINK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .mode      (mode),
    .disp_byte (disp_byte),
    .digit_sel (digit_sel),
    .blank     (blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: time-indexed frame behaviour ----------------
  int         t;
  logic       m_ft;
  logic       m_sel;
  logic [7:0] m_rx_hold, m_tx_hold, m_disp;
  logic       m_rx_seen, m_tx_seen, m_blank;
  int         m_blink;

  initial begin
    t = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_disp", 32'(disp_byte), 32'h00);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_sel", 32'(digit_sel), 32'h0);
        check("rst_ft", 32'(frame_tick), 32'h0);
        t = 0;
        m_rx_hold = 8'h00; m_tx_hold = 8'h00; m_disp = 8'h00;
        m_rx_seen = 1'b0;  m_tx_seen = 1'b0;  m_blank = 1'b1;
        m_blink = 0;
      end else begin
        m_ft  = (t % FRAME) == FRAME - 1;
        m_sel = ((t / DIV) % 2) == 1;
        check("cmp_disp", 32'(disp_byte), 32'(m_disp));
        check("cmp_blank", 32'(blank), 32'(m_blank));
        check("cmp_sel", 32'(digit_sel), 32'(m_sel));
        check("cmp_ft", 32'(frame_tick), 32'(m_ft));
        if (m_ft) begin
          if (!mode && m_rx_seen) begin
            m_disp  = m_rx_hold;
`ifdef DISP_BLINK_EN
            m_blank = (m_blink % 2) == 1;
`else
            m_blank = 1'b0;
`endif
          end else if (mode && m_tx_seen) begin
            m_disp  = m_tx_hold;
            m_blank = 1'b0;
          end else begin
            m_disp  = 8'h00;
            m_blank = 1'b1;
          end
          if (m_blink > 0) m_blink--;
        end
        if (rx_valid) begin
          m_rx_hold = rx_data;
          m_rx_seen = 1'b1;
          m_blink   = BLINK;
        end
        if (tx_load) begin
          m_tx_hold = tx_data;
          m_tx_seen = 1'b1;
        end
        t++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    tx_load = 1'b1;
    tx_data = d;
    step();
    tx_load = 1'b0;
  endtask

  // Asserts reset immediately, checks the asynchronous clear, holds it, releases just after an edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_async_disp"}, 32'(disp_byte), 32'h00);
    check({tag, "_async_blank"}, 32'(blank), 32'h1);
    check({tag, "_async_sel"}, 32'(digit_sel), 32'h0);
    check({tag, "_async_ft"}, 32'(frame_tick), 32'h0);
    rx_valid = 1'b0; tx_load = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  logic blink_exp [5];

  initial begin
    #2;
    // Idle run: blank, zero byte, digit toggles every 4, frame_tick every 8
    do_reset("init");
    goto_cyc(3);  check("idle_sel_c3", 32'(digit_sel), 32'h0);
    check("idle_ft_c3", 32'(frame_tick), 32'h0);
    goto_cyc(4);  check("idle_sel_c4", 32'(digit_sel), 32'h1);
    goto_cyc(7);  check("idle_ft_c7", 32'(frame_tick), 32'h1);
    goto_cyc(8);  check("idle_ft_c8", 32'(frame_tick), 32'h0);
    check("idle_sel_c8", 32'(digit_sel), 32'h0);
    goto_cyc(100);
    check("idle_blank_c100", 32'(blank), 32'h1);
    check("idle_disp_c100", 32'(disp_byte), 32'h00);

    // Receive 3C at cycle 10, shown from the frame_tick at 15
    do_reset("rx");
    goto_cyc(10); pulse_rx(8'h3C);
    goto_cyc(15); check("rx3c_before", 32'(disp_byte), 32'h00);
    goto_cyc(16); check("rx3c_disp", 32'(disp_byte), 32'h3C);
    check("rx3c_blank", 32'(blank), 32'h0);
    check("rx3c_sel0", 32'(digit_sel), 32'h0);
    goto_cyc(20); check("rx3c_sel1", 32'(digit_sel), 32'h1);
    check("rx3c_hold", 32'(disp_byte), 32'h3C);

    // A5 right after a frame_tick waits a whole frame
    goto_cyc(24); pulse_rx(8'hA5);
    goto_cyc(31); check("a5_midframe", 32'(disp_byte), 32'h3C);
    goto_cyc(32); check("a5_shown", 32'(disp_byte), 32'hA5);

    // Capture on the frame_tick cycle: old byte first, new one a frame later
    goto_cyc(39); check("ft_c39", 32'(frame_tick), 32'h1);
    pulse_rx(8'h66);
    goto_cyc(40); check("coinc_old", 32'(disp_byte), 32'hA5);
    goto_cyc(48); check("coinc_new", 32'(disp_byte), 32'h66);

    // Back-to-back captures keep the last byte
    goto_cyc(50); pulse_rx(8'h11); pulse_rx(8'h22); pulse_rx(8'h33);
    goto_cyc(56); check("b2b_last", 32'(disp_byte), 32'h33);

    // tx 7E then rx 12, mode switches mid-frame
    goto_cyc(58); pulse_tx(8'h7E); pulse_rx(8'h12);
    mode = 1'b1;
    goto_cyc(63); check("tx_midframe", 32'(disp_byte), 32'h33);
    goto_cyc(64); check("tx_7e", 32'(disp_byte), 32'h7E);
    check("tx_blank", 32'(blank), 32'h0);
    goto_cyc(66); mode = 1'b0;
    goto_cyc(72); check("back_rx_12", 32'(disp_byte), 32'h12);

    // Mode glitch shorter than a frame is ignored
    goto_cyc(74); mode = 1'b1;
    goto_cyc(76); mode = 1'b0;
    goto_cyc(80); check("glitch_ignored", 32'(disp_byte), 32'h12);

    // Simultaneous rx and tx captures both land
    goto_cyc(82);
    rx_valid = 1'b1; rx_data = 8'hC3; tx_load = 1'b1; tx_data = 8'h5A;
    step();
    rx_valid = 1'b0; tx_load = 1'b0;
    goto_cyc(88); check("both_rx", 32'(disp_byte), 32'hC3);
    goto_cyc(90); mode = 1'b1;
    goto_cyc(96); check("both_tx", 32'(disp_byte), 32'h5A);
    goto_cyc(100);

    // Reset mid-frame while showing 55; data must be lost afterwards
    do_reset("pre55");
    goto_cyc(2); pulse_rx(8'h55);
    goto_cyc(8); check("s55_disp", 32'(disp_byte), 32'h55);
    check("s55_blank", 32'(blank), 32'h0);
    goto_cyc(13); check("s55_sel_before_rst", 32'(digit_sel), 32'h1);
    do_reset("mid55");
    goto_cyc(3); check("post_sel_c3", 32'(digit_sel), 32'h0);
    goto_cyc(4); check("post_sel_c4", 32'(digit_sel), 32'h1);
    goto_cyc(8); check("post_blank", 32'(blank), 32'h1);
    check("post_disp", 32'(disp_byte), 32'h00);
    mode = 1'b1;
    goto_cyc(16); check("post_tx_unseen", 32'(blank), 32'h1);

    // Receive 09: blink pattern with the feature, steady display without
    do_reset("blink");
`ifdef DISP_BLINK_EN
    blink_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    blink_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    goto_cyc(2); pulse_rx(8'h09);
    goto_cyc(8); check("blink_disp", 32'(disp_byte), 32'h09);
    for (int f = 0; f < 5; f++) begin
      goto_cyc(8 + f * FRAME);
      check($sformatf("blink_f%0d", f), 32'(blank), 32'(blink_exp[f]));
    end
    goto_cyc(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
